// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared FSM states, legal oversampling ratios and parity helper for uart_rx_ctrl
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_rx_pkg;
  localparam logic [5:0] PRESC_8  = 6'd8;
  localparam logic [5:0] PRESC_16 = 6'd16;
  localparam logic [5:0] PRESC_32 = 6'd32;
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  function automatic logic [5:0] legal_prescale(input logic [5:0] p);
    return (p == PRESC_8 || p == PRESC_16 || p == PRESC_32) ? p : PRESC_8;
  endfunction
  function automatic logic par_bit(input logic [31:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction
endpackage

// File: rtl/data_sampling_RX.sv
// data_sampling_RX: 2-of-3 majority vote of RX_IN around the bit centre
module data_sampling_RX (
  input  logic       CLK_rx,
  input  logic       RST_rx,
  input  logic       RX_IN,
  input  logic       en,
  input  logic [5:0] edge_cnt,
  input  logic [5:0] half,
  output logic       sampled_bit
);
  logic [2:0] s;
  always_ff @(posedge CLK_rx or negedge RST_rx)
    if (!RST_rx) begin
      s <= 3'b0;
      sampled_bit <= 1'b0;
    end else if (en) begin
      if (edge_cnt == half - 6'd1) s[0] <= RX_IN;
      if (edge_cnt == half) s[1] <= RX_IN;
      if (edge_cnt == half + 6'd1) s[2] <= RX_IN;
      if (edge_cnt == half + 6'd2) sampled_bit <= (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    end
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: oversampled UART receive controller (IDLE/START/DATA/[PARITY]/STOP)
// Define UART_RX_PARITY_EN to add PAR_EN, PAR_TYP, Par_Error and the PARITY state.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK_rx,
  input  logic                  RST_rx,
  input  logic                  RX_IN,
  input  logic [5:0]            Prescale,
`ifdef UART_RX_PARITY_EN
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  Par_Error,
`endif
  input  logic                  Stop_Error,
  output logic                  stp_chk_en,
  output logic                  sampled_bit,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid
);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  state_t state;
  logic [5:0] p, ec, half;
  logic [BW-1:0] bc;
  logic [DATA_WIDTH-1:0] sh;
  logic last, frame_ok;
  assign half = p >> 1;
  assign last = ec == p - 6'd1;
`ifdef UART_RX_PARITY_EN
  assign frame_ok = !Stop_Error && !Par_Error;
`else
  assign frame_ok = !Stop_Error;
`endif
  data_sampling_RX u_samp (
    .CLK_rx(CLK_rx),
    .RST_rx(RST_rx),
    .RX_IN(RX_IN),
    .en(state != IDLE),
    .edge_cnt(ec),
    .half(half),
    .sampled_bit(sampled_bit)
  );
  always_ff @(posedge CLK_rx or negedge RST_rx)
    if (!RST_rx) begin
      state <= IDLE;
      p <= 6'd0;
      ec <= 6'd0;
      bc <= '0;
      sh <= '0;
      P_DATA <= '0;
      data_valid <= 1'b0;
      stp_chk_en <= 1'b0;
`ifdef UART_RX_PARITY_EN
      Par_Error <= 1'b0;
`endif
    end else begin
      data_valid <= 1'b0;
      stp_chk_en <= 1'b0;
      ec <= (state == IDLE || last) ? 6'd0 : ec + 6'd1;
      case (state)
        IDLE:
          if (!RX_IN) begin
            state <= START;
            p <= legal_prescale(Prescale);
          end
        START:
          if (last) state <= sampled_bit ? IDLE : DATA;
        DATA:
          if (last) begin
            sh <= DATA_WIDTH'({sampled_bit, sh} >> 1);
            bc <= bc + 1'b1;
            if (bc == BW'(DATA_WIDTH - 1)) begin
              bc <= '0;
`ifdef UART_RX_PARITY_EN
              state <= PAR_EN ? PARITY : STOP;
              if (!PAR_EN) Par_Error <= 1'b0;
`else
              state <= STOP;
`endif
            end
          end
`ifdef UART_RX_PARITY_EN
        PARITY:
          if (last) begin
            Par_Error <= par_bit(32'(sh), PAR_TYP) != sampled_bit;
            state <= STOP;
          end
`endif
        STOP: begin
          if (ec == half + 6'd2) stp_chk_en <= 1'b1;
          if (last) begin
            data_valid <= frame_ok;
            if (frame_ok) P_DATA <= sh;
            // a start bit already on the line goes straight to START so back-to-back frames keep their timing
            state <= RX_IN ? IDLE : START;
            if (!RX_IN) p <= legal_prescale(Prescale);
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed and randomized frames checked against a bit-timing reference model
module tb_uart_rx_ctrl;
  logic CLK_rx = 1'b0;
  logic RST_rx = 1'b0;
  logic RX_IN = 1'b1;
  logic [5:0] Prescale = 6'd8;
  logic Stop_Error = 1'b0;
  logic stp_chk_en, sampled_bit, data_valid;
  logic [7:0] P_DATA;
`ifdef UART_RX_PARITY_EN
  logic PAR_EN = 1'b0;
  logic PAR_TYP = 1'b0;
  logic Par_Error;
`endif
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int dv_q[$];
  int dvd_q[$];
  int stp_q[$];
  logic [7:0] exp_pdata = 8'h00;

  uart_rx_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK_rx(CLK_rx),
    .RST_rx(RST_rx),
    .RX_IN(RX_IN),
    .Prescale(Prescale),
`ifdef UART_RX_PARITY_EN
    .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP),
    .Par_Error(Par_Error),
`endif
    .Stop_Error(Stop_Error),
    .stp_chk_en(stp_chk_en),
    .sampled_bit(sampled_bit),
    .P_DATA(P_DATA),
    .data_valid(data_valid)
  );

  always #5 CLK_rx = ~CLK_rx;
  always @(posedge CLK_rx) cyc <= cyc + 1;
  always @(negedge CLK_rx) begin
    if (data_valid) begin
      dv_q.push_back(cyc);
      dvd_q.push_back(int'(P_DATA));
    end
    if (stp_chk_en) stp_q.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic clear_q();
    dv_q.delete();
    dvd_q.delete();
    stp_q.delete();
  endtask

  // Drives start, data LSB first, optional parity, stop; each bit held p cycles.
  task automatic send_frame(input int p, input logic [7:0] d, input logic stop, input logic has_par,
                            input logic pbit, input int nsend, output int c0);
    logic [10:0] fr;
    int n;
    fr = {1'b1, stop, d, 1'b0};
    if (has_par) fr = {stop, pbit, d, 1'b0};
    n = has_par ? 11 : 10;
    if (nsend > 0 && nsend < n) n = nsend;
    c0 = 0;
    for (int j = 0; j < n; j++)
      for (int i = 0; i < p; i++) begin
        @(negedge CLK_rx);
        if (j == 0 && i == 0) c0 = cyc;
        RX_IN = fr[j];
      end
  endtask

  task automatic run_frame(input string tag, input logic [5:0] pin, input logic [7:0] d, input logic stop,
                           input logic has_par, input logic ptyp, input logic pbit);
    int p, n, c0;
    logic good, perr;
    p = (pin == 6'd8 || pin == 6'd16 || pin == 6'd32) ? int'(pin) : 8;
    n = has_par ? 11 : 10;
    perr = has_par && (pbit != ((^d) ^ ptyp));
    good = stop && !perr;
    Prescale = pin;
    Stop_Error = !stop;
`ifdef UART_RX_PARITY_EN
    PAR_EN = has_par;
    PAR_TYP = ptyp;
`endif
    clear_q();
    send_frame(p, d, stop, has_par, pbit, 0, c0);
    @(negedge CLK_rx);
    RX_IN = 1'b1;
    repeat (2 * p) @(negedge CLK_rx);
    chk({tag, ":dv_count"}, dv_q.size(), good ? 1 : 0);
    if (good && dv_q.size() > 0) begin
      chk({tag, ":dv_cycle"}, dv_q[0], c0 + 1 + n * p);
      chk({tag, ":dv_data"}, dvd_q[0], int'(d));
    end
    chk({tag, ":stp_count"}, stp_q.size(), 1);
    if (stp_q.size() > 0) chk({tag, ":stp_cycle"}, stp_q[0], c0 + 1 + (n - 1) * p + p / 2 + 3);
    if (good) exp_pdata = d;
    chk({tag, ":p_data"}, P_DATA, exp_pdata);
`ifdef UART_RX_PARITY_EN
    chk({tag, ":par_err"}, Par_Error, perr);
`endif
  endtask

  initial begin
    int ca, cb, sel;
    logic [5:0] pr;
    repeat (3) @(negedge CLK_rx);
    chk("rst:p_data", P_DATA, 0);
    chk("rst:dv", data_valid, 0);
    chk("rst:stp", stp_chk_en, 0);
    chk("rst:sampled", sampled_bit, 0);
    RST_rx = 1'b1;
    repeat (4) @(negedge CLK_rx);

    run_frame("p8_a5", 6'd8, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef UART_RX_PARITY_EN
    run_frame("p16_par_bad", 6'd16, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b1);
    run_frame("p16_par_ok", 6'd16, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0);
`endif
    run_frame("p32_stop0", 6'd32, 8'h6E, 1'b0, 1'b0, 1'b0, 1'b0);

    Prescale = 6'd16;
    Stop_Error = 1'b0;
    clear_q();
    repeat (3) begin
      @(negedge CLK_rx);
      RX_IN = 1'b0;
    end
    @(negedge CLK_rx);
    RX_IN = 1'b1;
    repeat (40) @(negedge CLK_rx);
    chk("glitch:stp_count", stp_q.size(), 0);
    chk("glitch:dv_count", dv_q.size(), 0);
    chk("glitch:p_data", P_DATA, exp_pdata);
    run_frame("after_glitch", 6'd16, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);

    Prescale = 6'd8;
    Stop_Error = 1'b0;
    clear_q();
    send_frame(8, 8'h55, 1'b1, 1'b0, 1'b0, 0, ca);
    send_frame(8, 8'hFF, 1'b1, 1'b0, 1'b0, 0, cb);
    @(negedge CLK_rx);
    RX_IN = 1'b1;
    repeat (20) @(negedge CLK_rx);
    chk("b2b:dv_count", dv_q.size(), 2);
    if (dv_q.size() == 2) begin
      chk("b2b:first_cycle", dv_q[0], ca + 81);
      chk("b2b:spacing", dv_q[1] - dv_q[0], 80);
      chk("b2b:data0", dvd_q[0], 32'h55);
      chk("b2b:data1", dvd_q[1], 32'hFF);
    end
    exp_pdata = 8'hFF;

    for (int k = 0; k < 12; k++) begin
      sel = $urandom_range(0, 3);
      pr = (sel == 0) ? 6'd8 : (sel == 1) ? 6'd16 : (sel == 2) ? 6'd32 : 6'($urandom_range(0, 63));
`ifdef UART_RX_PARITY_EN
      run_frame("rand", pr, 8'($urandom), $urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), 1'($urandom));
`else
      run_frame("rand", pr, 8'($urandom), $urandom_range(0, 3) != 0, 1'b0, 1'b0, 1'b0);
`endif
      repeat ($urandom_range(0, 3)) @(negedge CLK_rx);
    end

    Prescale = 6'd8;
    Stop_Error = 1'b0;
`ifdef UART_RX_PARITY_EN
    PAR_EN = 1'b0;
`endif
    send_frame(8, 8'h3C, 1'b1, 1'b0, 1'b0, 4, ca);
    @(negedge CLK_rx);
    RST_rx = 1'b0;
    RX_IN = 1'b1;
    repeat (3) @(negedge CLK_rx);
    chk("inrst:p_data", P_DATA, 0);
    chk("inrst:dv", data_valid, 0);
    chk("inrst:stp", stp_chk_en, 0);
    chk("inrst:sampled", sampled_bit, 0);
`ifdef UART_RX_PARITY_EN
    chk("inrst:par_err", Par_Error, 0);
`endif
    exp_pdata = 8'h00;
    clear_q();
    RST_rx = 1'b1;
    repeat (30) @(negedge CLK_rx);
    chk("release:dv_count", dv_q.size(), 0);
    run_frame("rst_81", 6'd8, 8'h81, 1'b1, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
